majority_ballot_ctrl: RTL and testbench

Sequencing controller for the 4-input majority voter: opens a ballot, collects one vote from each of four voter channels over independent valid/ack handshakes, then evaluates the chair-tie-break majority rule and presents the decision on a valid/ready output. A per-ballot timeout closes voting when a voter is silent, and missing votes count as 0. The block sits between the voter agents and the downstream consumer of the decision.

---
 rtl/majority_ballot_ctrl.sv | 107 ++++++++++
 tb/tb_majority_ballot_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/majority_ballot_ctrl.sv
// Ballot sequencer for the 4-input majority voter: collects one vote per voter
// over valid/ack handshakes, applies the chair tie-break rule, holds the decision.
module majority_ballot_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic [3:0] vote_ack,
  input  logic       result_ready,
  output logic       result,
  output logic       result_valid,
  output logic       busy,
  output logic       timed_out,
  output logic [3:0] missing
);

  localparam int unsigned CW = 8;
  localparam int unsigned NV = 4;

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, HOLD} state_t;

  state_t          state;
  logic [NV-1:0]   ballot;
  logic [NV-1:0]   received;
  logic [CW-1:0]   counter;

  logic [NV-1:0]   accept_c;
  logic [NV-1:0]   received_nxt_c;
  logic [2:0]      ones_c;
  logic            majority_c;

  // First vote from each voter is accepted; repeats are dropped.
  always_comb begin
    accept_c       = vote_valid & ~received;
    received_nxt_c = received | accept_c;
  end

  // Chair (voter 3) breaks a 2-2 tie; missing votes already read as 0.
  always_comb begin
    ones_c     = 3'(ballot[0]) + 3'(ballot[1]) + 3'(ballot[2]) + 3'(ballot[3]);
    majority_c = (ones_c >= 3'd3) || ((ones_c == 3'd2) && ballot[3]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ballot       <= '0;
      received     <= '0;
      counter      <= '0;
      vote_ack     <= '0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timed_out    <= 1'b0;
      missing      <= '0;
    end else begin
      vote_ack <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= COLLECT;
            busy      <= 1'b1;
            ballot    <= '0;
            received  <= '0;
            counter   <= '0;
            timed_out <= 1'b0;
            missing   <= '0;
          end
        end
        COLLECT: begin
          vote_ack <= accept_c;
          ballot   <= (ballot & ~accept_c) | (vote_val & accept_c);
          received <= received_nxt_c;
          if (received_nxt_c == '1) begin
            state <= DECIDE;
          end else if (counter == CW'(TIMEOUT - 1)) begin
            state     <= DECIDE;
            timed_out <= 1'b1;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        DECIDE: begin
          result       <= majority_c;
          missing      <= ~received;
          result_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_majority_ballot_ctrl.sv
// Directed bench for majority_ballot_ctrl; decisions are checked by a monitor
// against a queue of hand-computed expectations.
module tb_majority_ballot_ctrl;

  typedef struct packed {
    logic       result;
    logic       timed_out;
    logic [3:0] missing;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vote_valid = '0;
  logic [3:0] vote_val = '0;
  logic [3:0] vote_ack;
  logic       result_ready = 1'b0;
  logic       result;
  logic       result_valid;
  logic       busy;
  logic       timed_out;
  logic [3:0] missing;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic rv_seen = 1'b0;

  majority_ballot_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(vote_ack),
    .result_ready(result_ready), .result(result), .result_valid(result_valid),
    .busy(busy), .timed_out(timed_out), .missing(missing)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard pop per rising result_valid.
  always @(negedge clk) begin
    if (result_valid && !rv_seen) begin
      rv_seen = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result_valid=1 expected no decision at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_result", 8'(result), 8'(e.result));
        check("sb_timed_out", 8'(timed_out), 8'(e.timed_out));
        check("sb_missing", 8'(missing), 8'(e.missing));
      end
    end
    if (!result_valid) rv_seen = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ballot(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_busy"}, 8'(busy), 8'd1);
  endtask

  task automatic vote(input logic [3:0] v, input logic [3:0] val,
                      input logic [3:0] exp_ack, input string nm);
    vote_valid = v;
    vote_val   = val;
    tick();
    vote_valid = '0;
    vote_val   = '0;
    check({nm, "_ack"}, 8'(vote_ack), 8'(exp_ack));
  endtask

  task automatic release_result(input string nm);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({nm, "_idle_busy"}, 8'(busy), 8'd0);
    check({nm, "_idle_rv"}, 8'(result_valid), 8'd0);
  endtask

  // Full ballot: all four votes on one edge, decision two edges later.
  task automatic ballot_full(input logic [3:0] val, input logic exp_res, input string nm);
    exp_t e;
    e = '{result: exp_res, timed_out: 1'b0, missing: 4'b0000};
    exp_q.push_back(e);
    start_ballot(nm);
    vote(4'b1111, val, 4'b1111, nm);
    check({nm, "_rv_e0"}, 8'(result_valid), 8'd0);
    tick();
    check({nm, "_rv_e1"}, 8'(result_valid), 8'd1);
    check({nm, "_ack_drop"}, 8'(vote_ack), 8'd0);
    release_result(nm);
  endtask

  initial begin
    exp_t e;
    #2 rst = 1'b1;
    repeat (2) tick();
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_rv", 8'(result_valid), 8'd0);
    check("rst_ack", 8'(vote_ack), 8'd0);
    check("rst_missing", 8'(missing), 8'd0);
    rst = 1'b0;
    tick();

    ballot_full(4'b0111, 1'b1, "all0111");
    ballot_full(4'b1001, 1'b1, "tie1001");
    ballot_full(4'b0011, 1'b0, "tie0011");
    ballot_full(4'b1000, 1'b0, "chair_only");
    ballot_full(4'b1110, 1'b1, "three1110");
    ballot_full(4'b0101, 1'b0, "tie0101");
    ballot_full(4'b0000, 1'b0, "none");

    // Staggered; voter 2 repeats with val=0, bit must stay 1 (1100 -> chair tie -> 1).
    e = '{result: 1'b1, timed_out: 1'b0, missing: 4'b0000};
    exp_q.push_back(e);
    start_ballot("stag");
    vote(4'b0001, 4'b0000, 4'b0001, "stag_v0");
    vote(4'b0010, 4'b0000, 4'b0010, "stag_v1");
    vote(4'b0100, 4'b0100, 4'b0100, "stag_v2");
    vote(4'b0100, 4'b0000, 4'b0000, "stag_v2rep");
    vote(4'b1000, 4'b1000, 4'b1000, "stag_v3");
    check("stag_rv_e0", 8'(result_valid), 8'd0);
    tick();
    check("stag_rv_e1", 8'(result_valid), 8'd1);
    release_result("stag");

    // Timeout: voters 0 and 3 vote yes on COLLECT edge 1, rest silent.
    e = '{result: 1'b1, timed_out: 1'b1, missing: 4'b0110};
    exp_q.push_back(e);
    start_ballot("tmo");
    vote(4'b1001, 4'b1001, 4'b1001, "tmo_v");
    repeat (14) tick();
    check("tmo_busy_e15", 8'(busy), 8'd1);
    check("tmo_rv_e15", 8'(result_valid), 8'd0);
    tick();
    check("tmo_rv_e16", 8'(result_valid), 8'd0);
    tick();
    check("tmo_rv_e17", 8'(result_valid), 8'd1);
    check("tmo_flag", 8'(timed_out), 8'd1);

    // HOLD with ready low: start and votes must have no effect.
    for (int i = 0; i < 5; i++) begin
      start      = 1'b1;
      vote_valid = 4'b1111;
      vote_val   = 4'b0000;
      tick();
      check("hold_ack", 8'(vote_ack), 8'd0);
      check("hold_rv", 8'(result_valid), 8'd1);
      check("hold_result", 8'(result), 8'd1);
      check("hold_missing", 8'(missing), 8'(4'b0110));
    end
    start      = 1'b0;
    vote_valid = '0;
    release_result("hold");
    check("idle_keep_missing", 8'(missing), 8'(4'b0110));
    check("idle_keep_tmo", 8'(timed_out), 8'd1);
    tick();
    check("idle_stays", 8'(busy), 8'd0);

    // Asynchronous reset mid-COLLECT with an ack in flight.
    start_ballot("rstmid");
    vote(4'b0011, 4'b0011, 4'b0011, "rstmid_v");
    rst = 1'b1;
    #1;
    check("arst_ack", 8'(vote_ack), 8'd0);
    check("arst_busy", 8'(busy), 8'd0);
    check("arst_rv", 8'(result_valid), 8'd0);
    check("arst_tmo", 8'(timed_out), 8'd0);
    check("arst_missing", 8'(missing), 8'd0);
    check("arst_result", 8'(result), 8'd0);
    #1 rst = 1'b0;
    tick();
    ballot_full(4'b1000, 1'b0, "post_rst");

    repeat (3) tick();
    check("sb_drained", 8'(exp_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
